// File: rtl/am_pkg.sv
// Shared definitions for the active-message receive path: header field
// positions and the splitter FSM state type.
package am_pkg;

    localparam int HANDLER_HI = 59;
    localparam int HANDLER_LO = 56;
    localparam int DEST_HI    = 39;
    localparam int DEST_LO    = 24;
    localparam int NARGS_HI   = 23;
    localparam int NARGS_LO   = 20;

    typedef enum logic [1:0] {
        ST_HEADER,
        ST_ARGS,
        ST_DATA
    } am_state_t;

    function automatic logic [3:0] am_handler_id(input logic [63:0] hdr);
        return hdr[HANDLER_HI:HANDLER_LO];
    endfunction

    function automatic logic [3:0] am_nargs(input logic [63:0] hdr);
        return hdr[NARGS_HI:NARGS_LO];
    endfunction

endpackage

// File: rtl/axis_reg_slot.sv
// Single-entry registered AXI-Stream output: a load replaces the slot,
// otherwise a valid&ready handshake empties it.
module axis_reg_slot
    import am_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  last
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;

    // A load in the same cycle as a drain takes priority and keeps the slot full.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            last_d  = load_last;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign last  = last_q;

endmodule

// File: rtl/am_handler_splitter.sv
// Splits the incoming AM stream: headers and payload to the receive engine,
// headers plus handler arguments to the handler wrapper.
module am_handler_splitter
    import am_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_handler_tdata,
    output logic                  m_axis_handler_tvalid,
    output logic                  m_axis_handler_tlast,
    input  logic                  m_axis_handler_tready,
    output logic [DATA_WIDTH-1:0] m_axis_data_tdata,
    output logic                  m_axis_data_tvalid,
    output logic                  m_axis_data_tlast,
    input  logic                  m_axis_data_tready,
    output logic [CNT_WIDTH-1:0]  handler_msg_count,
    output logic [CNT_WIDTH-1:0]  trunc_err_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    am_state_t            state_q, state_d;
    logic [3:0]           arg_cnt_q, arg_cnt_d;
    logic [CNT_WIDTH-1:0] handler_cnt_q, handler_cnt_d;
    logic [CNT_WIDTH-1:0] trunc_cnt_q, trunc_cnt_d;

    logic       accept;
    logic       h_load, h_last_in;
    logic       d_load, d_last_in;
    logic [3:0] hdr_handler, hdr_nargs;

    // Either full slot that cannot drain stalls the whole input.
    assign s_axis_tready = (!m_axis_handler_tvalid | m_axis_handler_tready) &
                           (!m_axis_data_tvalid    | m_axis_data_tready);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign hdr_handler   = am_handler_id(s_axis_tdata);
    assign hdr_nargs     = am_nargs(s_axis_tdata);

    always_comb begin
        state_d       = state_q;
        arg_cnt_d     = arg_cnt_q;
        handler_cnt_d = handler_cnt_q;
        trunc_cnt_d   = trunc_cnt_q;
        h_load        = 1'b0;
        h_last_in     = 1'b0;
        d_load        = 1'b0;
        d_last_in     = 1'b0;
        if (accept) begin
            unique case (state_q)
                ST_HEADER: begin
                    d_load    = 1'b1;
                    d_last_in = s_axis_tlast;
                    arg_cnt_d = hdr_nargs;
                    if (hdr_handler != 4'd0) begin
                        h_load    = 1'b1;
                        h_last_in = (hdr_nargs == 4'd0) | s_axis_tlast;
                        if (handler_cnt_q != CNT_MAX) handler_cnt_d = handler_cnt_q + CNT_ONE;
                    end
                    if (s_axis_tlast)                                  state_d = ST_HEADER;
                    else if (hdr_handler != 4'd0 && hdr_nargs != 4'd0) state_d = ST_ARGS;
                    else                                               state_d = ST_DATA;
                end
                ST_ARGS: begin
                    h_load    = 1'b1;
                    h_last_in = (arg_cnt_q == 4'd1) | s_axis_tlast;
                    arg_cnt_d = arg_cnt_q - 4'd1;
                    if (s_axis_tlast) begin
                        // The data path already holds an open header; close it with a copy of this beat.
                        d_load    = 1'b1;
                        d_last_in = 1'b1;
                        state_d   = ST_HEADER;
                        if (arg_cnt_q > 4'd1 && trunc_cnt_q != CNT_MAX)
                            trunc_cnt_d = trunc_cnt_q + CNT_ONE;
                    end else if (arg_cnt_q == 4'd1) begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    d_load    = 1'b1;
                    d_last_in = s_axis_tlast;
                    if (s_axis_tlast) state_d = ST_HEADER;
                end
                default: state_d = ST_HEADER;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= ST_HEADER;
            arg_cnt_q     <= 4'd0;
            handler_cnt_q <= '0;
            trunc_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            arg_cnt_q     <= arg_cnt_d;
            handler_cnt_q <= handler_cnt_d;
            trunc_cnt_q   <= trunc_cnt_d;
        end
    end

    axis_reg_slot #(.DATA_WIDTH(DATA_WIDTH)) u_handler_slot (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (h_load),
        .load_data (s_axis_tdata),
        .load_last (h_last_in),
        .ready     (m_axis_handler_tready),
        .valid     (m_axis_handler_tvalid),
        .data      (m_axis_handler_tdata),
        .last      (m_axis_handler_tlast)
    );

    axis_reg_slot #(.DATA_WIDTH(DATA_WIDTH)) u_data_slot (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (d_load),
        .load_data (s_axis_tdata),
        .load_last (d_last_in),
        .ready     (m_axis_data_tready),
        .valid     (m_axis_data_tvalid),
        .data      (m_axis_data_tdata),
        .last      (m_axis_data_tlast)
    );

    assign handler_msg_count = handler_cnt_q;
    assign trunc_err_count   = trunc_cnt_q;

endmodule
